player_bullet: RTL and testbench

Reimu's shot generator and the player-to-boss direction of the bullet/hit interface. Spawns up to four upward-travelling player bullets from Reimu's position on the fire input. Tests each bullet against the boss hitbox and maintains the boss HP counter. Outputs feed the VGA sprite mux (bullet valid/x/y) and the game FSM (boss_hit, boss_hp, boss_defeated); runs on the same clk22 game tick as boss_bullet.

---
 rtl/player_bullet.sv | 172 +++++++++++++++++
 tb/tb_player_bullet.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/player_bullet.sv
// Reimu's shot generator: four upward player bullets, boss hitbox test and boss HP tracking.
// All state advances on the clk22 game tick.

module player_bullet_slot #(
  parameter int SPEED = 10,
  parameter int HIT_W = 20,
  parameter int HIT_H = 24
) (
  input  logic       act,
  input  logic       armed,
  input  logic [9:0] bx,
  input  logic [9:0] by,
  input  logic [9:0] bossx,
  input  logic [9:0] bossy,
  output logic       hit,
  output logic       off
);
  // 11-bit zero-extended so box edges never wrap at the screen limits
  logic [10:0] x, y, ex, ey;
  assign x  = {1'b0, bx};
  assign y  = {1'b0, by};
  assign ex = {1'b0, bossx};
  assign ey = {1'b0, bossy};

  assign hit = armed & act
             & (x + 11'(HIT_W) > ex) & (x < ex + 11'(HIT_W))
             & (y + 11'(HIT_H) > ey) & (y < ey + 11'(HIT_H));
  assign off = act & ~hit
             & ((y < 11'(8 + SPEED)) | (x < 11'd8) | (x > 11'd432));
endmodule

module player_bullet #(
  parameter int SPEED    = 10,
  parameter int COOLDOWN = 4,
  parameter int BOSS_HP  = 63,
  parameter int HIT_W    = 20,
  parameter int HIT_H    = 24
) (
  input  logic       clk22,
  input  logic       rst_n,
  input  logic       fire,
  input  logic       boss,
  input  logic [9:0] reimux,
  input  logic [9:0] reimuy,
  input  logic [9:0] bossx,
  input  logic [9:0] bossy,
  output logic       reimu_bullet1,
  output logic       reimu_bullet2,
  output logic       reimu_bullet3,
  output logic       reimu_bullet4,
  output logic [9:0] reimu_bulletx1,
  output logic [9:0] reimu_bulletx2,
  output logic [9:0] reimu_bulletx3,
  output logic [9:0] reimu_bulletx4,
  output logic [9:0] reimu_bullety1,
  output logic [9:0] reimu_bullety2,
  output logic [9:0] reimu_bullety3,
  output logic [9:0] reimu_bullety4,
  output logic       boss_hit,
  output logic [5:0] boss_hp,
  output logic       boss_defeated
);
  localparam int NS = 4;
  localparam int CW = $clog2(COOLDOWN + 2);

  logic [NS-1:0]       act, act_nx, hit, off;
  logic [NS-1:0][9:0]  bx, by, bx_nx, by_nx;
  logic [CW-1:0]       cd, cd_nx;
  logic [5:0]          hp, hp_nx;
  logic                hit_q, hit_nx, def, def_nx, boss_d;
  logic [2:0]          hits;
  logic                run, taken;

  assign run = boss & boss_d;

  genvar g;
  generate
    for (g = 0; g < NS; g++) begin : g_slot
      player_bullet_slot #(.SPEED(SPEED), .HIT_W(HIT_W), .HIT_H(HIT_H)) u_slot (
        .act(act[g]), .armed(run & ~def),
        .bx(bx[g]), .by(by[g]), .bossx(bossx), .bossy(bossy),
        .hit(hit[g]), .off(off[g])
      );
    end
  endgenerate

  always_comb begin
    act_nx = act;
    bx_nx  = bx;
    by_nx  = by;
    cd_nx  = (cd != '0) ? cd - CW'(1) : '0;
    hp_nx  = hp;
    def_nx = def;
    hit_nx = 1'b0;
    hits   = '0;
    taken  = 1'b0;
    for (int i = 0; i < NS; i++) hits = hits + 3'(hit[i]);

    if (!boss) begin
      act_nx = '0;
      bx_nx  = '0;
      by_nx  = '0;
      cd_nx  = '0;
    end else if (!boss_d) begin
      act_nx = '0;
      bx_nx  = '0;
      by_nx  = '0;
      hp_nx  = 6'(BOSS_HP);
      def_nx = 1'b0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (hit[i] || off[i]) begin
          act_nx[i] = 1'b0;
          bx_nx[i]  = '0;
          by_nx[i]  = '0;
        end else if (act[i]) begin
          by_nx[i] = by[i] - 10'(SPEED);
        end
      end
      hit_nx = (hits != '0);
      hp_nx  = ({3'b0, hits} >= hp) ? '0 : hp - {3'b0, hits};
      def_nx = def | (hit_nx & (hp_nx == '0));
      // slots freed this tick are not reusable until the next one
      if (fire && cd == '0 && !def) begin
        for (int i = 0; i < NS; i++) begin
          if (!act[i] && !taken) begin
            taken     = 1'b1;
            act_nx[i] = 1'b1;
            bx_nx[i]  = reimux;
            by_nx[i]  = reimuy - 10'd16;
            cd_nx     = CW'(COOLDOWN);
          end
        end
      end
    end
  end

  always_ff @(posedge clk22 or negedge rst_n) begin
    if (!rst_n) begin
      act    <= '0;
      bx     <= '0;
      by     <= '0;
      cd     <= '0;
      hp     <= 6'(BOSS_HP);
      hit_q  <= 1'b0;
      def    <= 1'b0;
      boss_d <= 1'b0;
    end else begin
      act    <= act_nx;
      bx     <= bx_nx;
      by     <= by_nx;
      cd     <= cd_nx;
      hp     <= hp_nx;
      hit_q  <= hit_nx;
      def    <= def_nx;
      boss_d <= boss;
    end
  end

  assign {reimu_bullet4, reimu_bullet3, reimu_bullet2, reimu_bullet1} = act;
  assign reimu_bulletx1 = bx[0];
  assign reimu_bulletx2 = bx[1];
  assign reimu_bulletx3 = bx[2];
  assign reimu_bulletx4 = bx[3];
  assign reimu_bullety1 = by[0];
  assign reimu_bullety2 = by[1];
  assign reimu_bullety3 = by[2];
  assign reimu_bullety4 = by[3];
  assign boss_hit       = hit_q;
  assign boss_hp        = hp;
  assign boss_defeated  = def;
endmodule

// File: tb/tb_player_bullet.sv
// Scoreboard bench for player_bullet: stimulus queues expected spawn/retire/hit events,
// a negedge monitor pops and compares them as the DUT shows them.

module tb_player_bullet;
  logic       clk22 = 1'b0, rst_n = 1'b0, fire = 1'b0, boss = 1'b0;
  logic [9:0] reimux = '0, reimuy = '0, bossx = '0, bossy = '0;
  logic       b1, b2, b3, b4, boss_hit, boss_defeated;
  logic [9:0] x1, x2, x3, x4, y1, y2, y3, y4;
  logic [5:0] boss_hp;

  player_bullet dut (
    .clk22(clk22), .rst_n(rst_n), .fire(fire), .boss(boss),
    .reimux(reimux), .reimuy(reimuy), .bossx(bossx), .bossy(bossy),
    .reimu_bullet1(b1), .reimu_bullet2(b2), .reimu_bullet3(b3), .reimu_bullet4(b4),
    .reimu_bulletx1(x1), .reimu_bulletx2(x2), .reimu_bulletx3(x3), .reimu_bulletx4(x4),
    .reimu_bullety1(y1), .reimu_bullety2(y2), .reimu_bullety3(y3), .reimu_bullety4(y4),
    .boss_hit(boss_hit), .boss_hp(boss_hp), .boss_defeated(boss_defeated)
  );

  always #5 clk22 = ~clk22;

  logic [3:0] act;
  logic [9:0] ox[4], oy[4];
  assign act = {b4, b3, b2, b1};
  assign ox[0] = x1; assign ox[1] = x2; assign ox[2] = x3; assign ox[3] = x4;
  assign oy[0] = y1; assign oy[1] = y2; assign oy[2] = y3; assign oy[3] = y4;

  typedef struct { int slot; int x; int y; } ev_t;
  typedef struct { int hp; int def; } hit_t;
  ev_t  spawn_q[$], ret_q[$];
  hit_t hit_q[$];

  int   errors = 0, checks = 0;
  logic quiet = 1'b1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk22);
    #1;
  endtask

  task automatic push_sp(input int s, input int x, input int y);
    ev_t e; e.slot = s; e.x = x; e.y = y; spawn_q.push_back(e);
  endtask

  task automatic push_ret(input int s, input int y);
    ev_t e; e.slot = s; e.x = 0; e.y = y; ret_q.push_back(e);
  endtask

  task automatic push_hit(input int hp, input int def);
    hit_t h; h.hp = hp; h.def = def; hit_q.push_back(h);
  endtask

  task automatic chk_idle(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s slot%0d active", tag, i + 1), act[i], 0);
      chk($sformatf("%s slot%0d xy", tag, i + 1), ox[i] | oy[i], 0);
    end
  endtask

  // monitor
  logic [3:0] pact = '0;
  int px[4], py[4];
  always @(negedge clk22) begin
    if (!quiet) begin
      for (int i = 0; i < 4; i++) begin
        if (act[i] && !pact[i]) begin
          if (spawn_q.size() == 0) chk($sformatf("unexpected spawn slot%0d", i + 1), 1, 0);
          else begin
            ev_t e;
            e = spawn_q.pop_front();
            chk("spawn slot", i, e.slot);
            chk("spawn x", ox[i], e.x);
            chk("spawn y", oy[i], e.y);
          end
        end else if (!act[i] && pact[i]) begin
          if (ret_q.size() == 0) chk($sformatf("unexpected retire slot%0d", i + 1), 1, 0);
          else begin
            ev_t e;
            e = ret_q.pop_front();
            chk("retire slot", i, e.slot);
            chk("retire last y", py[i], e.y);
            chk("retire xy cleared", ox[i] | oy[i], 0);
          end
        end else if (act[i]) begin
          chk($sformatf("slot%0d step y", i + 1), oy[i], py[i] - 10);
          chk($sformatf("slot%0d hold x", i + 1), ox[i], px[i]);
        end
      end
      if (boss_hit) begin
        if (hit_q.size() == 0) chk("unexpected boss_hit", 1, 0);
        else begin
          hit_t h;
          h = hit_q.pop_front();
          chk("hit boss_hp", boss_hp, h.hp);
          chk("hit boss_defeated", boss_defeated, h.def);
        end
      end
    end
    pact = act;
    for (int i = 0; i < 4; i++) begin px[i] = ox[i]; py[i] = oy[i]; end
  end

  initial begin
    // reset values while held
    #17;
    chk_idle("in reset");
    chk("reset boss_hp", boss_hp, 63);
    chk("reset boss_hit", boss_hit, 0);
    chk("reset defeated", boss_defeated, 0);
    rst_n = 1'b1;
    quiet = 1'b0;

    // boss=0: fire ignored
    fire = 1'b1;
    tick(10);
    chk_idle("no boss");
    chk("no boss hp", boss_hp, 63);
    chk("no boss hit", boss_hit, 0);

    // single shot hits boss at y=114; fire also high on the entry tick (no spawn there)
    reimux = 10'd200; reimuy = 10'd400; bossx = 10'd200; bossy = 10'd100;
    boss = 1'b1;
    push_sp(0, 200, 384); push_ret(0, 114); push_hit(62, 0);
    tick(2);
    fire = 1'b0;
    tick(35);
    chk("after hit hp", boss_hp, 62);
    chk_idle("after hit");

    // re-entry reloads HP; boss off to the side, bullet leaves at y=14
    boss = 1'b0; tick(1);
    boss = 1'b1; bossx = 10'd50; tick(1);
    chk("entry reload hp", boss_hp, 63);
    push_sp(0, 200, 384); push_ret(0, 14);
    fire = 1'b1; tick(1); fire = 1'b0;
    tick(45);
    chk("miss hp", boss_hp, 63);
    chk("miss boss_hit", boss_hit, 0);

    // fire held: spawns at 0,5,10,15 then 39 and 44 when slots free up
    bossx = 10'd400;
    for (int i = 0; i < 6; i++) push_sp(i % 4, 200, 384);
    for (int i = 0; i < 6; i++) push_ret(i % 4, 14);
    fire = 1'b1; tick(45); fire = 1'b0;
    tick(60);
    chk_idle("burst drained");

    // 62 point-blank hits bring HP to 1
    boss = 1'b0; tick(1);
    boss = 1'b1; bossx = 10'd200; bossy = 10'd100; reimux = 10'd200; reimuy = 10'd130;
    tick(1);
    for (int k = 1; k <= 62; k++) begin
      push_sp(0, 200, 114); push_ret(0, 114); push_hit(63 - k, 0);
    end
    fire = 1'b1; tick(306); fire = 1'b0;
    tick(6);
    chk("hp at one", boss_hp, 1);
    chk("not yet defeated", boss_defeated, 0);

    // two bullets aligned at the same y, then boss moved under both
    bossx = 10'd400; reimuy = 10'd400;
    push_sp(0, 200, 384);
    fire = 1'b1; tick(1); fire = 1'b0;
    tick(4);
    reimuy = 10'd350;
    push_sp(1, 200, 334);
    fire = 1'b1; tick(1); fire = 1'b0;
    bossx = 10'd200;
    push_ret(0, 114); push_ret(1, 114); push_hit(0, 1);
    tick(30);
    chk("double hit hp saturates", boss_hp, 0);
    chk("defeated set", boss_defeated, 1);
    fire = 1'b1; tick(10); fire = 1'b0;
    chk_idle("defeated no spawn");
    boss = 1'b0; tick(1);
    chk("defeated holds boss=0", boss_defeated, 1);
    chk("hp holds boss=0", boss_hp, 0);
    boss = 1'b1; tick(1);
    chk("re-entry hp", boss_hp, 63);
    chk("re-entry defeated", boss_defeated, 0);

    // async reset mid-flight after a hit
    reimuy = 10'd130;
    push_sp(0, 200, 114); push_ret(0, 114); push_hit(62, 0);
    fire = 1'b1; tick(1); fire = 1'b0;
    tick(5);
    bossx = 10'd400; reimuy = 10'd400;
    push_sp(0, 200, 384);
    fire = 1'b1; tick(1); fire = 1'b0;
    tick(3);
    chk("pre-reset hp", boss_hp, 62);
    chk("pre-reset in flight", b1, 1);
    #2;
    quiet = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_idle("async reset");
    chk("async reset hp", boss_hp, 63);
    chk("async reset hit", boss_hit, 0);
    chk("async reset defeated", boss_defeated, 0);
    #3;
    rst_n = 1'b1;
    quiet = 1'b0;
    tick(5);

    chk("spawn queue drained", spawn_q.size(), 0);
    chk("retire queue drained", ret_q.size(), 0);
    chk("hit queue drained", hit_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
